// File: rtl/score_multiplier_pkg.sv
// Shared constants and types for the score multiplier slice.
// Operand and result widths live here so the points calculator and the
// multiplier agree on them without repeating literals.
package score_multiplier_pkg;

  // Default constant factor applied to both score channels
  localparam int COEF_DEFAULT       = 100;
  // Bit width of the factor, which is also the number of shift-add iterations
  localparam int COEF_WIDTH_DEFAULT = 7;
  // Width of each operand coming from the points calculator
  localparam int OPERAND_WIDTH      = 6;
  // Result width: 63 * 130 = 8190 still fits in 13 bits
  localparam int RESULT_WIDTH       = 13;

  // Sequencer states; the unused fourth encoding falls back to idle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Zero-extend an operand to the accumulator width
  function automatic logic [RESULT_WIDTH-1:0] widen_operand(
    input logic [OPERAND_WIDTH-1:0] op
  );
    return {{(RESULT_WIDTH-OPERAND_WIDTH){1'b0}}, op};
  endfunction

endpackage

// File: rtl/score_multiplier_shift_add.sv
// One channel of the multiplier: holds the captured operand and an
// accumulator, and adds the operand shifted by the current iteration index
// whenever the matching factor bit is set.
module shift_add_unit
  import score_multiplier_pkg::*;
#(
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic                     step,
  input  logic                     coef_bit,
  input  logic [SHIFT_WIDTH-1:0]   shift_amt,
  output logic [RESULT_WIDTH-1:0]  acc
);

  logic [OPERAND_WIDTH-1:0] operand_q;
  logic [RESULT_WIDTH-1:0]  addend;

  // Shifted copy of the captured operand for the current iteration
  always_comb begin
    addend = widen_operand(operand_q) << shift_amt;
  end

  // Capture clears the accumulator; each step adds the addend if the bit is set
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      acc       <= '0;
    end else if (capture) begin
      operand_q <= operand_in;
      acc       <= '0;
    end else if (step && coef_bit) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/score_multiplier.sv
// Multiplies the time and discovered-pairs operands by a constant factor
// using a shared shift-add sequencer and two accumulator channels.
// Results only change on the edge that enters DONE, so they never show
// partial sums, and done pulses for exactly that one cycle.
module score_multiplier
  import score_multiplier_pkg::*;
#(
  parameter int COEF       = COEF_DEFAULT,
  parameter int COEF_WIDTH = COEF_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] time_multiplier,
  input  logic [OPERAND_WIDTH-1:0] discovered_pairs_multiplier,
  output logic [RESULT_WIDTH-1:0]  mult_time_result,
  output logic [RESULT_WIDTH-1:0]  mult_discovered_pairs_result,
  output logic                     busy,
  output logic                     done
);

  // Counter must be able to hold COEF_WIDTH itself (the "all bits done" value)
  localparam int CNT_W      = $clog2(COEF_WIDTH + 1);
  localparam int COEF_VEC_W = 1 << CNT_W;
  // Factor padded so every counter value indexes a real bit
  localparam logic [COEF_VEC_W-1:0] COEF_VEC = COEF_VEC_W'(COEF);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(COEF_WIDTH);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    capture;
  logic                    step;
  logic                    load_results;
  logic                    coef_bit;
  logic [RESULT_WIDTH-1:0] acc_time;
  logic [RESULT_WIDTH-1:0] acc_pairs;

  // State register; reset wins over any simultaneous start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only matters in idle, done always falls back to idle
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_CALC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes and status outputs decoded from the current state
  always_comb begin
    capture      = 1'b0;
    step         = 1'b0;
    load_results = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = start;
      end
      ST_CALC: begin
        busy         = 1'b1;
        step         = (cnt_q != LAST_CNT);
        load_results = (cnt_q == LAST_CNT);
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Iteration counter, cleared on capture and advanced once per step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (capture) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Factor bit processed on the current iteration
  always_comb begin
    coef_bit = COEF_VEC[cnt_q];
  end

  shift_add_unit #(
    .SHIFT_WIDTH (CNT_W)
  ) u_time_channel (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .operand_in (time_multiplier),
    .step       (step),
    .coef_bit   (coef_bit),
    .shift_amt  (cnt_q),
    .acc        (acc_time)
  );

  shift_add_unit #(
    .SHIFT_WIDTH (CNT_W)
  ) u_pairs_channel (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .operand_in (discovered_pairs_multiplier),
    .step       (step),
    .coef_bit   (coef_bit),
    .shift_amt  (cnt_q),
    .acc        (acc_pairs)
  );

  // Result registers only update on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_time_result             <= '0;
      mult_discovered_pairs_result <= '0;
    end else if (load_results) begin
      mult_time_result             <= acc_time;
      mult_discovered_pairs_result <= acc_pairs;
    end
  end

endmodule

// File: tb/tb_score_multiplier.sv
// Randomised self-checking bench for score_multiplier: results are predicted
// as operand * COEF, and the latency, busy window and done pulse are checked
// against the expected start-to-done timing.
module tb_score_multiplier;

  localparam int COEF = 100;
  localparam int CW   = 7;
  localparam int LAT  = CW + 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  time_multiplier;
  logic [5:0]  discovered_pairs_multiplier;
  logic [12:0] mult_time_result;
  logic [12:0] mult_discovered_pairs_result;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  // Reference model state: results the design should currently show
  logic [12:0] model_time;
  logic [12:0] model_pairs;

  score_multiplier #(
    .COEF       (COEF),
    .COEF_WIDTH (CW)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .start                        (start),
    .time_multiplier              (time_multiplier),
    .discovered_pairs_multiplier  (discovered_pairs_multiplier),
    .mult_time_result             (mult_time_result),
    .mult_discovered_pairs_result (mult_discovered_pairs_result),
    .busy                         (busy),
    .done                         (done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] product(input logic [5:0] op);
    int p;
    p = int'(op) * COEF;
    return p[12:0];
  endfunction

  // Drive one start pulse, then scramble operands so late changes are visible
  task automatic pulse_start(input logic [5:0] t_op, input logic [5:0] p_op);
    time_multiplier             = t_op;
    discovered_pairs_multiplier = p_op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    time_multiplier             = 6'($urandom_range(63, 0));
    discovered_pairs_multiplier = 6'($urandom_range(63, 0));
  endtask

  // Watch LAT+3 cycles after the start edge and record what happened
  task automatic observe(output int done_edge, output int done_count,
                         output bit busy_ok, output bit held_ok);
    logic [12:0] hold_t;
    logic [12:0] hold_p;
    hold_t     = model_time;
    hold_p     = model_pairs;
    done_edge  = -1;
    done_count = 0;
    busy_ok    = (busy === 1'b1);
    held_ok    = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_count++;
        if (done_edge < 0) done_edge = i;
      end
      if (i <= LAT && busy !== 1'b1) busy_ok = 1'b0;
      if (i == LAT + 1 && busy !== 1'b0) busy_ok = 1'b0;
      if (i < LAT && (mult_time_result !== hold_t || mult_discovered_pairs_result !== hold_p))
        held_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    time_multiplier = 6'd9;
    discovered_pairs_multiplier = 6'd9;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy got=%0b want=0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_done got=%0b want=0", done);
    end
    n_checks++;
    if (mult_time_result !== 13'd0 || mult_discovered_pairs_result !== 13'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_results got=%0d/%0d want=0/0",
               mult_time_result, mult_discovered_pairs_result);
    end
    start = 1'b0;
    rst = 1'b0;
    model_time  = '0;
    model_pairs = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_calc(input string name, input logic [5:0] t_op, input logic [5:0] p_op);
    int done_edge;
    int done_count;
    bit busy_ok;
    bit held_ok;
    pulse_start(t_op, p_op);
    observe(done_edge, done_count, busy_ok, held_ok);
    model_time  = product(t_op);
    model_pairs = product(p_op);
    n_checks++;
    if (done_edge != LAT || done_count != 1) begin
      n_fail++;
      $display("[TB] FAIL %s_done_timing got edge=%0d count=%0d want edge=%0d count=1",
               name, done_edge, done_count, LAT);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++;
      $display("[TB] FAIL %s_busy_window got=wrong want=high for edges 0..%0d", name, LAT);
    end
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("[TB] FAIL %s_results_held got=changed want=previous values until done", name);
    end
    n_checks++;
    if (mult_time_result !== model_time || mult_discovered_pairs_result !== model_pairs) begin
      n_fail++;
      $display("[TB] FAIL %s_results got=%0d/%0d want=%0d/%0d", name,
               mult_time_result, mult_discovered_pairs_result, model_time, model_pairs);
    end
  endtask

  task automatic test_basic();
    check_calc("basic_12_5", 6'd12, 6'd5);
  endtask

  task automatic test_max_operands();
    check_calc("max_63_63", 6'd63, 6'd63);
  endtask

  task automatic test_zero_operand();
    check_calc("zero_0_32", 6'd0, 6'd32);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      check_calc($sformatf("random%0d", n), 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)));
    end
  endtask

  task automatic test_ignore_restart();
    int done_count;
    int done_edge;
    done_count = 0;
    done_edge  = -1;
    pulse_start(6'd21, 6'd44);
    for (int i = 1; i <= LAT + 4; i++) begin
      if (i == 3) begin
        time_multiplier             = 6'd1;
        discovered_pairs_multiplier = 6'd2;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        done_count++;
        if (done_edge < 0) done_edge = i;
      end
    end
    model_time  = product(6'd21);
    model_pairs = product(6'd44);
    n_checks++;
    if (done_count != 1 || done_edge != LAT) begin
      n_fail++;
      $display("[TB] FAIL restart_single_done got count=%0d edge=%0d want count=1 edge=%0d",
               done_count, done_edge, LAT);
    end
    n_checks++;
    if (mult_time_result !== model_time || mult_discovered_pairs_result !== model_pairs) begin
      n_fail++;
      $display("[TB] FAIL restart_results got=%0d/%0d want=%0d/%0d",
               mult_time_result, mult_discovered_pairs_result, model_time, model_pairs);
    end
  endtask

  task automatic test_reset_abort();
    int done_count;
    done_count = 0;
    pulse_start(6'd50, 6'd60);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_time  = '0;
    model_pairs = '0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_status got busy=%0b done=%0b want 0/0", busy, done);
    end
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_count++;
    end
    n_checks++;
    if (done_count != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done got=%0d pulses want=0", done_count);
    end
    n_checks++;
    if (mult_time_result !== 13'd0 || mult_discovered_pairs_result !== 13'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_results got=%0d/%0d want=0/0",
               mult_time_result, mult_discovered_pairs_result);
    end
    check_calc("after_abort_7_1", 6'd7, 6'd1);
  endtask

  task automatic test_back_to_back();
    check_calc("b2b_first", 6'd33, 6'd17);
    check_calc("b2b_second", 6'd17, 6'd33);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    start = 1'b0;
    time_multiplier = '0;
    discovered_pairs_multiplier = '0;
    model_time  = '0;
    model_pairs = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_max_operands();
    test_zero_operand();
    test_ignore_restart();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=still running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/score_multiplier.md
SCORE_MULTIPLIER -- requirements
Module: score_multiplier

Interface
REQ-001 SHALL have parameter COEF, default 100, meaning the constant factor applied to both operands; legal range 1..130, so 63*COEF fits 13 bits.
REQ-002 SHALL have parameter COEF_WIDTH, default 7, meaning the bit width of COEF and the number of iterations.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request pulse to capture both operands and begin a calculation.
REQ-006 SHALL have port time_multiplier, input, 6 bits: time operand from the points calculator.
REQ-007 SHALL have port discovered_pairs_multiplier, input, 6 bits: pairs operand from the points calculator.
REQ-008 SHALL have port mult_time_result, output, 13 bits: time_multiplier*COEF, registered.
REQ-009 SHALL have port mult_discovered_pairs_result, output, 13 bits: discovered_pairs_multiplier*COEF, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a calculation is in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse marking that new results are valid.

Function
REQ-012 SHALL implement three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, SHALL latch both operands, clear both accumulators and the iteration counter, and enter CALC at the next edge.
REQ-014 In CALC, SHALL process COEF bit k on iteration k (k=0..COEF_WIDTH-1), adding operand<<k to the channel accumulator when that bit is 1; both channels run in parallel.
REQ-015 SHALL leave CALC for DONE after exactly COEF_WIDTH iterations.
REQ-016 On the edge entering DONE, SHALL load both accumulators into the result outputs, and done SHALL be 1 for exactly that one cycle; DONE then returns to IDLE unconditionally.
REQ-017 Latency: start sampled at edge N SHALL give updated results and done=1 in the cycle following edge N+COEF_WIDTH+1 (edge N+8 at default).
REQ-018 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-020 Operand changes after capture SHALL NOT affect the calculation in progress.
REQ-021 Results SHALL hold their last values until the next DONE; they SHALL never show partial sums.
REQ-022 Accumulator arithmetic SHALL be 13-bit unsigned with no overflow at legal COEF; an operand of 0 SHALL yield 0.
REQ-023 Any undefined state SHALL return to IDLE.

Reset
REQ-024 rst=1 SHALL force state IDLE, results 0, busy 0, done 0, and clear the counter and accumulators.
REQ-025 rst mid-calculation SHALL abort it with no done pulse; results SHALL remain 0.
REQ-026 rst SHALL have priority over a simultaneous start.

Structure
REQ-027 COEF default, operand width (6) and result width (13) SHALL be defined in the shared macros header next to the card macros.
REQ-028 The per-channel accumulate step SHALL be one sub-module, shift_add_unit, instantiated twice under a shared FSM and counter.

Verification
REQ-029 Start with operands 12 and 5 -> 1200 and 500 with done=1 exactly 8 cycles after start; busy high for cycles 1..8.
REQ-030 Start with operands 63 and 63 -> 6300 and 6300, with no overflow.
REQ-031 Start with operands 0 and 32 -> 0 and 3200; previous results held until done.
REQ-032 Start at cycle 0, start again at cycle 3 with changed operands -> one done only, results from the cycle-0 operands.
REQ-033 rst at cycle 4 of a calculation -> outputs 0, no done pulse; a following start (operands 7 and 1) -> 700 and 100.
